// File: rtl/axi2ocp_mux.sv
// axi2ocp_mux: N-port AXI4-Lite-style slave to single OCP master funnel.
//
// Arbitrates single-beat read and write requests from NUM_PORTS AXI slave
// ports round-robin. It issues one OCP transaction at a time and routes the
// OCP response back to the port that made the request.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   aw*/w*/b*/ar*/r*            per-port AXI channels; port p lives at
//                               lane [p*W +: W] of the packed vectors
//   mcmd, maddr, mdata          registered OCP request (0 IDLE, 1 WR, 2 RD)
//   scmdaccept, sresp, sdata    OCP slave accept and response
//
// Optional feature: define AXI2OCP_TIMEOUT_EN to abort a response wait after
// TIMEOUT_CYCLES cycles in RESP with an SLVERR response and zero read data.
module axi2ocp_mux #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        awvalid,
    output logic [NUM_PORTS-1:0]        awready,
    input  logic [NUM_PORTS*ADDR_W-1:0] awaddr,
    input  logic [NUM_PORTS-1:0]        wvalid,
    output logic [NUM_PORTS-1:0]        wready,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        bvalid,
    input  logic [NUM_PORTS-1:0]        bready,
    output logic [NUM_PORTS*2-1:0]      bresp,
    input  logic [NUM_PORTS-1:0]        arvalid,
    output logic [NUM_PORTS-1:0]        arready,
    input  logic [NUM_PORTS*ADDR_W-1:0] araddr,
    output logic [NUM_PORTS-1:0]        rvalid,
    input  logic [NUM_PORTS-1:0]        rready,
    output logic [NUM_PORTS*DATA_W-1:0] rdata,
    output logic [NUM_PORTS*2-1:0]      rresp,
    output logic [2:0]                  mcmd,
    output logic [ADDR_W-1:0]           maddr,
    output logic [DATA_W-1:0]           mdata,
    input  logic                        scmdaccept,
    input  logic [1:0]                  sresp,
    input  logic [DATA_W-1:0]           sdata
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [2:0] CmdIdle    = 3'd0;
    localparam logic [2:0] CmdWr      = 3'd1;
    localparam logic [2:0] CmdRd      = 3'd2;
    localparam logic [1:0] SrespNull  = 2'd0;
    localparam logic [1:0] SrespErr   = 2'd3;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {StIdle, StCmd, StResp, StRet} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       port_q, port_d;
    logic                is_wr_q, is_wr_d;
    logic [2:0]          mcmd_q, mcmd_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mdata_q, mdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;

    logic [NUM_PORTS-1:0] req;
    logic                 grant_vld;
    logic [PW-1:0]        grant_idx;
    logic                 grant_wr;

`ifdef AXI2OCP_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // A write needs both AW and W; a lone AW or W never forms a request.
    assign req = (awvalid & wvalid) | arvalid;

    // Round-robin search starting at the port after the last grant.
    always_comb begin : arb
        int            j;
        logic [PW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = 0;
        cand      = '0;
        for (int i = 1; i <= int'(NUM_PORTS); i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= int'(NUM_PORTS)) begin
                j = j - int'(NUM_PORTS);
            end
            cand = PW'(j);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant_wr = awvalid[grant_idx] & wvalid[grant_idx];
    end

    always_comb begin : fsm
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        port_d   = port_q;
        is_wr_d  = is_wr_q;
        mcmd_d   = mcmd_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        rdata_d  = rdata_q;
        resp_d   = resp_q;
        awready  = '0;
        wready   = '0;
        arready  = '0;
`ifdef AXI2OCP_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                // rst_n gating keeps the readys low while reset is held.
                if (grant_vld && rst_n) begin
                    if (grant_wr) begin
                        awready[grant_idx] = 1'b1;
                        wready[grant_idx]  = 1'b1;
                        mcmd_d             = CmdWr;
                        maddr_d            = awaddr[grant_idx*ADDR_W +: ADDR_W];
                        mdata_d            = wdata[grant_idx*DATA_W +: DATA_W];
                    end else begin
                        arready[grant_idx] = 1'b1;
                        mcmd_d             = CmdRd;
                        maddr_d            = araddr[grant_idx*ADDR_W +: ADDR_W];
                        mdata_d            = '0;
                    end
                    port_d   = grant_idx;
                    is_wr_d  = grant_wr;
                    rr_ptr_d = grant_idx;
                    state_d  = StCmd;
                end
            end
            StCmd: begin
                if (scmdaccept) begin
                    mcmd_d  = CmdIdle;
                    state_d = StResp;
`ifdef AXI2OCP_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StResp: begin
                if (sresp != SrespNull) begin
                    resp_d  = (sresp == SrespErr) ? RespSlverr : RespOkay;
                    rdata_d = is_wr_q ? '0 : sdata;
                    state_d = StRet;
`ifdef AXI2OCP_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    resp_d  = RespSlverr;
                    rdata_d = '0;
                    state_d = StRet;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            StRet: begin
                if (is_wr_q ? bready[port_q] : rready[port_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= PW'(NUM_PORTS - 1);
            port_q   <= '0;
            is_wr_q  <= 1'b0;
            mcmd_q   <= CmdIdle;
            maddr_q  <= '0;
            mdata_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= '0;
`ifdef AXI2OCP_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            port_q   <= port_d;
            is_wr_q  <= is_wr_d;
            mcmd_q   <= mcmd_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
`ifdef AXI2OCP_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign mcmd  = mcmd_q;
    assign maddr = maddr_q;
    assign mdata = mdata_q;

    // Only the owning port's response lane is driven; other lanes read zero.
    always_comb begin : resp_out
        bvalid = '0;
        rvalid = '0;
        bresp  = '0;
        rresp  = '0;
        rdata  = '0;
        if (state_q == StRet) begin
            if (is_wr_q) begin
                bvalid[port_q]         = 1'b1;
                bresp[port_q*2 +: 2]   = resp_q;
            end else begin
                rvalid[port_q]                 = 1'b1;
                rresp[port_q*2 +: 2]           = resp_q;
                rdata[port_q*DATA_W +: DATA_W] = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_axi2ocp_mux.sv
module tb_axi2ocp_mux;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    awvalid, awready, wvalid, wready, bvalid, bready;
    logic [NP-1:0]    arvalid, arready, rvalid, rready;
    logic [NP*AW-1:0] awaddr, araddr;
    logic [NP*DW-1:0] wdata, rdata;
    logic [NP*2-1:0]  bresp, rresp;
    logic [2:0]       mcmd;
    logic [AW-1:0]    maddr;
    logic [DW-1:0]    mdata, sdata;
    logic             scmdaccept;
    logic [1:0]       sresp;

    axi2ocp_mux #(
        .NUM_PORTS      (NP),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rresp      (rresp),
        .mcmd       (mcmd),
        .maddr      (maddr),
        .mdata      (mdata),
        .scmdaccept (scmdaccept),
        .sresp      (sresp),
        .sdata      (sdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          port;
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   t0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                        input int p, input bit wr, input logic [1:0] r, input logic [31:0] rd,
                        input bit with_rsp);
        cmd_t ce;
        rsp_t re;
        ce.cmd = c; ce.addr = a; ce.data = d;
        cmd_q.push_back(ce);
        if (with_rsp) begin
            re.port = p; re.wr = wr; re.resp = r; re.data = rd;
            rsp_q.push_back(re);
        end
    endtask

    // Waits for a grant, checks it targets port p in the given direction,
    // and optionally drops the granted channel valids after the handshake.
    task automatic wait_grant(input int p, input bit wr, input bit drop, output int tg);
        logic [5:0] exp;
        int k = 0;
        #1;
        while (({awready, wready, arready} == 6'd0) && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        exp = wr ? {2'(1 << p), 2'(1 << p), 2'b00} : {2'b00, 2'b00, 2'(1 << p)};
        check("grant", {awready, wready, arready}, exp);
        tg = cyc;
        @(posedge clk);
        #1;
        if (drop) begin
            if (wr) begin
                awvalid[p] = 1'b0;
                wvalid[p]  = 1'b0;
            end else begin
                arvalid[p] = 1'b0;
            end
        end
    endtask

    // OCP slave: checks the command, holds accept low for 'hold' cycles,
    // then answers with 'code' in the first RESP cycle.
    task automatic serve(input int hold, input logic [1:0] code, input logic [31:0] sd);
        cmd_t e;
        int k = 0;
        @(negedge clk);
        while (mcmd === 3'd0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        e = cmd_q.pop_front();
        check("ocp_cmd", {mcmd, maddr, mdata}, {e.cmd, e.addr, e.data});
        scmdaccept = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("cmd_hold", {mcmd, maddr, mdata}, {e.cmd, e.addr, e.data});
            check("no_accept", {awready, wready, arready}, 6'd0);
            if (i == hold - 1) scmdaccept = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        scmdaccept = 1'b0;
        sresp      = code;
        sdata      = sd;
        @(posedge clk);
        #1;
        sresp = 2'd0;
        sdata = '0;
    endtask

    task automatic expect_resp(input int tg, input int lat);
        rsp_t e;
        int k = 0;
        e = rsp_q.pop_front();
        @(negedge clk);
        while (!(e.wr ? bvalid[e.port] : rvalid[e.port]) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(e.wr ? "bvalid" : "rvalid", e.wr ? bvalid : rvalid, 64'(1 << e.port));
        if (lat > 0) check("latency", 64'(cyc - tg), 64'(lat));
        if (e.wr) begin
            check("bresp", bresp[e.port*2 +: 2], e.resp);
            bready[e.port] = 1'b1;
        end else begin
            check("rresp", rresp[e.port*2 +: 2], e.resp);
            check("rdata", rdata[e.port*DW +: DW], e.data);
            rready[e.port] = 1'b1;
        end
        @(posedge clk);
        #1;
        bready = '0;
        rready = '0;
        check("valid_clear", {bvalid, rvalid}, 4'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ocp"}, {mcmd, maddr, mdata}, 67'd0);
        check({tag, "_hs"}, {awready, wready, arready, bvalid, rvalid}, 10'd0);
        check({tag, "_rsp"}, {bresp, rresp, rdata}, 72'd0);
    endtask

    initial begin
        awvalid = '0; wvalid = '0; arvalid = '0; bready = '0; rready = '0;
        awaddr = '0; wdata = '0; araddr = '0;
        scmdaccept = 1'b0; sresp = 2'd0; sdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single write from port 0, minimum latency.
        @(negedge clk);
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        awaddr[31:0] = 32'h100; wdata[31:0] = 32'hDEADBEEF;
        push(3'd1, 32'h100, 32'hDEADBEEF, 0, 1'b1, 2'b00, 32'h0, 1'b1);
        wait_grant(0, 1'b1, 1'b1, t0);
        serve(0, 2'd1, 32'h0);
        expect_resp(t0, 3);

        // Read from port 1 answered with ERR.
        @(negedge clk);
        arvalid[1] = 1'b1; araddr[63:32] = 32'h200;
        push(3'd2, 32'h200, 32'h0, 1, 1'b0, 2'b10, 32'h5A5A5A5A, 1'b1);
        wait_grant(1, 1'b0, 1'b1, t0);
        serve(0, 2'd3, 32'h5A5A5A5A);
        expect_resp(t0, 3);

        // Both ports request continuously: grants alternate 0,1,0,1.
        @(negedge clk);
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        awaddr[31:0] = 32'h300; wdata[31:0] = 32'h11110000;
        arvalid[1] = 1'b1; araddr[63:32] = 32'h400;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(3'd1, 32'h300, 32'h11110000, 0, 1'b1, 2'b00, 32'h0, 1'b1);
            else            push(3'd2, 32'h400, 32'h0, 1, 1'b0, 2'b00, 32'h1000 + i, 1'b1);
            wait_grant(i % 2, (i % 2) == 0, 1'b0, t0);
            serve(0, 2'd1, 32'h1000 + i);
            expect_resp(t0, 0);
        end
        awvalid = '0; wvalid = '0; arvalid = '0;

        // Port 0 with AW, W and AR together: write first, read later.
        @(negedge clk);
        awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
        awaddr[31:0] = 32'h500; wdata[31:0] = 32'hCAFEF00D; araddr[31:0] = 32'h600;
        push(3'd1, 32'h500, 32'hCAFEF00D, 0, 1'b1, 2'b00, 32'h0, 1'b1);
        push(3'd2, 32'h600, 32'h0, 0, 1'b0, 2'b00, 32'h77, 1'b1);
        wait_grant(0, 1'b1, 1'b1, t0);
        serve(0, 2'd1, 32'h0);
        expect_resp(t0, 3);
        wait_grant(0, 1'b0, 1'b1, t0);
        serve(0, 2'd1, 32'h77);
        expect_resp(t0, 3);

        // scmdaccept low for 5 cycles while port 0 is also waiting.
        @(negedge clk);
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        awaddr[63:32] = 32'h700; wdata[63:32] = 32'h12345678;
        arvalid[0] = 1'b1; araddr[31:0] = 32'h780;
        push(3'd1, 32'h700, 32'h12345678, 1, 1'b1, 2'b00, 32'h0, 1'b1);
        push(3'd2, 32'h780, 32'h0, 0, 1'b0, 2'b00, 32'h99, 1'b1);
        wait_grant(1, 1'b1, 1'b1, t0);
        serve(5, 2'd1, 32'h0);
        expect_resp(t0, 0);
        wait_grant(0, 1'b0, 1'b1, t0);
        serve(0, 2'd1, 32'h99);
        expect_resp(t0, 3);

`ifdef AXI2OCP_TIMEOUT_EN
        // No response from the slave: SLVERR after 8 RESP cycles.
        @(negedge clk);
        arvalid[1] = 1'b1; araddr[63:32] = 32'h800;
        push(3'd2, 32'h800, 32'h0, 1, 1'b0, 2'b10, 32'h0, 1'b1);
        wait_grant(1, 1'b0, 1'b1, t0);
        serve(0, 2'd0, 32'hFFFFFFFF);
        expect_resp(t0, 10);
`endif

        // Reset in RESP drops the transaction immediately.
        @(negedge clk);
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        awaddr[31:0] = 32'h900; wdata[31:0] = 32'hABCD;
        push(3'd1, 32'h900, 32'hABCD, 0, 1'b1, 2'b00, 32'h0, 1'b0);
        wait_grant(0, 1'b1, 1'b1, t0);
        begin
            cmd_t e;
            @(negedge clk);
            e = cmd_q.pop_front();
            check("rst_ocp_cmd", {mcmd, maddr, mdata}, {e.cmd, e.addr, e.data});
            scmdaccept = 1'b1;
            @(posedge clk);
            #1;
            scmdaccept = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        bready = '1;
        rready = '1;
        @(negedge clk);
        rst_n = 1'b1;
        sresp = 2'd1;
        repeat (3) begin
            @(negedge clk);
            check("no_resp_after_reset", {bvalid, rvalid}, 4'd0);
        end
        sresp = 2'd0;
        bready = '0;
        rready = '0;

        // After reset port 0 wins against port 1.
        @(negedge clk);
        arvalid = 2'b11; araddr = {32'hB00, 32'hA00};
        push(3'd2, 32'hA00, 32'h0, 0, 1'b0, 2'b00, 32'h42, 1'b1);
        wait_grant(0, 1'b0, 1'b1, t0);
        arvalid[1] = 1'b0;
        serve(0, 2'd1, 32'h42);
        expect_resp(t0, 3);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi2ocp_mux.md
# axi2ocp_mux

Parametrised N-port AXI4-Lite-style slave to single OCP master funnel; next generation of the fixed two-port interconnect. Each AXI port carries the full AW/W/B/AR/R channel set. The block arbitrates single-beat read and write requests round-robin across ports and issues one OCP transaction at a time. It then routes the OCP response back to the requesting port.

## Interface
- NUM_PORTS, 2, number of AXI slave ports (1..8)
- ADDR_W, 32, address width (AXI and OCP)
- DATA_W, 32, data width (AXI and OCP)
- TIMEOUT_CYCLES, 256, response timeout limit (used only with AXI2OCP_TIMEOUT_EN)
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- awvalid, awready  in/out  NUM_PORTS  per-port write-address handshake
- awaddr  in  NUM_PORTS*ADDR_W  per-port write address, port p at [p*ADDR_W +: ADDR_W]
- wvalid, wready  in/out  NUM_PORTS  per-port write-data handshake
- wdata  in  NUM_PORTS*DATA_W  per-port write data
- bvalid  out  NUM_PORTS  write response valid; bready  in  NUM_PORTS
- bresp  out  NUM_PORTS*2  write response
- arvalid, arready  in/out  NUM_PORTS  read-address handshake; araddr  in  NUM_PORTS*ADDR_W
- rvalid  out  NUM_PORTS; rready  in  NUM_PORTS; rdata  out  NUM_PORTS*DATA_W; rresp  out  NUM_PORTS*2
- mcmd  out  3  OCP command: 0 IDLE, 1 WR, 2 RD
- maddr  out  ADDR_W; mdata  out  DATA_W
- scmdaccept  in  1  OCP command accept
- sresp  in  2  0 NULL, 1 DVA, 3 ERR; sdata  in  DATA_W

## Operation
- Request of port p:
  - Write request when awvalid[p] and wvalid[p] are both high.
  - Read request when arvalid[p] is high.
  - When a port has both, the write wins.
- FSM states: IDLE, CMD, RESP, RET.
- IDLE:
  - Pick the first requesting port, searching from rr_ptr+1 modulo NUM_PORTS.
  - In the same cycle, drive awready[p] and wready[p] (write) or arready[p] (read) high combinationally, for the granted port only.
  - Capture the address and data, the port index and the direction.
  - Set rr_ptr to p, then go to CMD.
- CMD: drive mcmd/maddr/mdata from the captured values; hold them stable until scmdaccept=1, then go to RESP.
- RESP: wait for sresp≠NULL.
  - DVA maps to resp 2'b00; ERR maps to 2'b10.
  - On a read, capture sdata.
  - Go to RET.
- RET: hold bvalid[p] (write) or rvalid[p] (read) with the resp and data until the matching ready is high, then go to IDLE.
- Only one transaction is outstanding. Every other port sees all readys low and must hold its valids.
- sresp≠NULL outside RESP is ignored.
- Reset values: all readys and valids 0; mcmd 0; maddr, mdata, rdata, bresp, rresp 0; state IDLE; rr_ptr NUM_PORTS-1, so port 0 wins first.
- Reset asserted mid-transaction: everything returns to reset values immediately. The in-flight transaction is dropped and no response is issued.

## Timing
- AXI accept occurs in the same cycle as the grant in IDLE.
- mcmd is valid from the next cycle.
- Minimum request-to-response latency, with scmdaccept=1 and sresp DVA the cycle after accept:
  - cycle 0: AXI accept
  - cycle 1: mcmd
  - cycle 2: sresp sampled
  - cycle 3: bvalid/rvalid high
- A new grant is possible in the cycle after the B/R handshake.
- mcmd/maddr/mdata come from registers. Only the AXI readys are combinational, from valids and state.
- A master asserting only one of awvalid or wvalid is never granted.

## Configuration
- AXI2OCP_TIMEOUT_EN defined:
  - A counter runs in RESP and clears on entry.
  - When it reaches TIMEOUT_CYCLES with sresp still NULL, the block forces resp=2'b10 and rdata=0 and goes to RET.
  - A late sresp is ignored.
- Undefined: no counter; RESP waits indefinitely.

## Test plan
- Single write from port 0: awaddr=0x100, wdata=0xDEADBEEF, scmdaccept=1, sresp=DVA.
  - Required: mcmd=1, maddr=0x100, mdata=0xDEADBEEF.
  - Required: bvalid[0] at cycle 3 with bresp=0.
- Read from port 1 with sresp=ERR and sdata=0x5A5A5A5A -> rvalid[1], rresp=2'b10, rdata=0x5A5A5A5A.
- Both ports request continuously (NUM_PORTS=2) -> grants alternate 0,1,0,1; neither port is granted twice in a row.
- Port 0 has aw, w and ar valid together -> write issued first; read issued on a later grant.
- scmdaccept held low for 5 cycles -> mcmd/maddr/mdata stable all 5 cycles; no second AXI accept during that time.
- With AXI2OCP_TIMEOUT_EN and TIMEOUT_CYCLES=8, sresp stays NULL -> rvalid with rresp=2'b10 after 8 RESP cycles.
- Reset asserted in RESP -> all outputs are at reset values the same cycle.
